// File: rtl/mem_access_unit_if.sv
// Data-memory handshake bundle between the MEM-stage access unit and the data memory.
// The unit is the master: it raises dmem_req and holds address/data until dmem_ack.
interface mem_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: turns aligned loads/stores into a req/ack data-memory
// transaction, stalls the upstream pipeline while it is outstanding, aborts with
// a sticky error on timeout or misalignment, and passes other ops straight through.
//
// state | meaning
// IDLE  | no transaction; an aligned access starts one (stall already high)
// REQ   | dmem_req held until ack or until TIMEOUT request cycles have elapsed
// DONE  | one cycle presenting captured data on MemData; pipeline released
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] MEM_ALUResult,
    input  logic [31:0] MEM_WriteData,
    input  logic [4:0]  MEM_rd,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic        MEM_MemToReg,
    input  logic        MEM_RegWrite,
    input  logic        MEM_VRegWrite,

    output logic [31:0] MemData,
    output logic [31:0] ALUResult,
    output logic [4:0]  rd,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic        VRegWrite,

    mem_access_unit_if.master dmem,

    output logic        stall,
    output logic        mem_err,
    output logic [31:0] err_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter value seen during the last permitted request cycle.
    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic        stall_c;
    logic        req_c;

    logic mem_op;
    logic aligned;
    logic access;
    logic misaligned;
    logic is_load;

    assign mem_op     = MEM_MemRead | MEM_MemWrite;
    assign aligned    = (MEM_ALUResult[1:0] == 2'b00);
    assign access     = mem_op & aligned;
    assign misaligned = mem_op & ~aligned;
    // A read+write op is handled as a store, so only pure reads capture data.
    assign is_load    = MEM_MemRead & ~MEM_MemWrite;

    // State, wait counter, captured data and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            data_q     <= 32'd0;
            err_q      <= 1'b0;
            err_addr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Next-state logic, transaction bookkeeping and stall/request generation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        stall_c    = 1'b0;
        req_c      = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (access) begin
                    state_d = REQ;
                    stall_c = 1'b1;
                end else if (misaligned) begin
                    err_d      = 1'b1;
                    err_addr_d = MEM_ALUResult;
                end
            end
            REQ: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                cnt_d   = 4'(cnt_q + 4'd1);
                // Ack takes priority over a timeout landing in the same cycle.
                if (dmem.dmem_ack) begin
                    if (is_load) begin
                        data_d = dmem.dmem_rdata;
                    end
                    state_d = DONE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == CNT_LAST) begin
                    data_d     = 32'hDEADBEEF;
                    err_d      = 1'b1;
                    err_addr_d = MEM_ALUResult;
                    state_d    = DONE;
                    cnt_d      = 4'd0;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Reset must drop stall at once even though an access is still presented in IDLE.
    assign stall = stall_c & rst_n;

    assign dmem.dmem_req   = req_c;
    assign dmem.dmem_we    = req_c & MEM_MemWrite;
    assign dmem.dmem_addr  = MEM_ALUResult;
    assign dmem.dmem_wdata = MEM_WriteData;

    assign MemData   = (state_q == DONE) ? data_q : 32'd0;
    assign ALUResult = MEM_ALUResult;
    assign rd        = MEM_rd;
    assign MemToReg  = MEM_MemToReg;
    assign RegWrite  = MEM_RegWrite  & ~stall & ~misaligned;
    assign VRegWrite = MEM_VRegWrite & ~stall & ~misaligned;

    assign mem_err  = err_q;
    assign err_addr = err_addr_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, the maximum REQ cycles without ack before abort (range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have inputs MEM_ALUResult 32 (address/result), MEM_WriteData 32, MEM_rd 5, MEM_MemRead 1, MEM_MemWrite 1, MEM_MemToReg 1, MEM_RegWrite 1, MEM_VRegWrite 1, all from the EX/MEM register.
REQ-005 SHALL have outputs MemData 32, ALUResult 32, rd 5, MemToReg 1, RegWrite 1, VRegWrite 1, all feeding the MEM/WB register.
REQ-006 SHALL have outputs dmem_req 1, dmem_we 1, dmem_addr 32, dmem_wdata 32, and inputs dmem_rdata 32, dmem_ack 1 (data-memory handshake).
REQ-007 SHALL have outputs stall 1 (freeze PC/IF/ID/EX and EX/MEM), mem_err 1 (sticky error) and err_addr 32.

Function
REQ-008 SHALL implement FSM states IDLE, REQ, DONE.
REQ-009 access = (MEM_MemRead | MEM_MemWrite) & (MEM_ALUResult[1:0] == 0); MemRead and MemWrite both high SHALL be treated as a write.
REQ-010 IDLE: access -> REQ, stall=1 combinationally in that cycle; otherwise remain IDLE, stall=0.
REQ-011 REQ: dmem_req=1, dmem_we=MEM_MemWrite, dmem_addr=MEM_ALUResult, dmem_wdata=MEM_WriteData; stall=1; wait counter increments each REQ cycle.
REQ-012 REQ with dmem_ack=1: a load captures dmem_rdata into an internal data register; -> DONE.
REQ-013 REQ with the counter at TIMEOUT and no ack: capture 32'hDEADBEEF, set mem_err, latch err_addr=MEM_ALUResult; -> DONE.
REQ-014 REQ: ack and timeout in the same cycle -> ack wins, no error.
REQ-015 DONE: stall=0, dmem_req=0, MemData = captured register; -> IDLE unconditionally (one cycle); counter cleared.
REQ-016 dmem_ack outside REQ SHALL be ignored.
REQ-017 A non-memory op SHALL pass through with zero latency: stall=0, MemData=0.
REQ-018 Misaligned MemRead/MemWrite SHALL perform no access: stall=0, RegWrite=VRegWrite=0 that cycle, mem_err set, err_addr latched.
REQ-019 ALUResult, rd and MemToReg SHALL always equal the MEM_* inputs combinationally.
REQ-020 RegWrite/VRegWrite SHALL equal MEM_RegWrite/MEM_VRegWrite except forced 0 while stall=1 (bubble).
REQ-021 Upstream SHALL hold the MEM_* inputs stable while stall=1; the block need not re-register them.
REQ-022 Aligned load with ack in the first REQ cycle: stall high 2 cycles; data visible on MemData in the DONE cycle.
REQ-023 Back-to-back accesses: DONE -> IDLE -> REQ; no two accesses overlap.
REQ-024 mem_err SHALL clear only on reset.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, counter 0, data register 0, mem_err 0, err_addr 0, dmem_req 0, dmem_we 0.
REQ-026 Reset mid-REQ SHALL abort the access with no further dmem_req.
REQ-027 After rst_n rises, the first rising clk edge SHALL evaluate IDLE normally.

Verification
REQ-028 Load addr 0x100, ack at the 3rd REQ cycle, rdata 0x12345678 -> stall high 4 cycles, MemData=0x12345678 in DONE, RegWrite low during stall.
REQ-029 Store addr 0x20, wdata 0xCAFEF00D, immediate ack -> dmem_we=1 for 1 cycle, stall 2 cycles, mem_err=0.
REQ-030 Load with no ack, TIMEOUT=15 -> 15 REQ cycles, MemData=0xDEADBEEF, mem_err=1, err_addr=addr.
REQ-031 Load addr 0x102 -> no dmem_req, stall=0, RegWrite forced 0, mem_err=1, err_addr=0x102.
REQ-032 rst_n low during the 2nd REQ cycle -> dmem_req=0 and stall=0 asynchronously; the next load completes normally.
REQ-033 Non-memory op, ALUResult 0xAAAA5555 -> same-cycle pass-through, stall=0, MemData=0.
